// File: rtl/aib_pkg.sv
// Shared types and default constants for the AIB Tx arbitration slice.
package aib_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } aib_arb_state_t;

    localparam int AIB_TX_DATA_W     = 72;
    localparam int AIB_ARB_MAX_BURST = 16;

endpackage

// File: rtl/aib_rr_pick.sv
// Combinational round-robin picker: first eligible index at or above i_ptr,
// wrapping from NUM_REQ-1 back to 0.
module aib_rr_pick
    import aib_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_elig,
    input  logic [IW-1:0]      i_ptr,
    output logic               o_any,
    output logic [IW-1:0]      o_idx
);

    localparam int          SW     = IW + 1;
    localparam logic [IW:0] NREQ_W = SW'(NUM_REQ);

    logic [IW:0]   sum_g  [NUM_REQ];
    logic [IW:0]   wrap_g [NUM_REQ];
    logic [IW-1:0] cand   [NUM_REQ];

    // Explicit modulo so non-power-of-two requester counts wrap correctly.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign sum_g[gi]  = {1'b0, i_ptr} + SW'(gi);
        assign wrap_g[gi] = (sum_g[gi] >= NREQ_W) ? (sum_g[gi] - NREQ_W) : sum_g[gi];
        assign cand[gi]   = wrap_g[gi][IW-1:0];
    end

    // Walk from the farthest offset down so the nearest eligible one wins.
    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_elig[cand[k]]) begin
                o_any = 1'b1;
                o_idx = cand[k];
            end
        end
    end

endmodule

// File: rtl/aib_tx_arbiter.sv
// Round-robin burst arbiter feeding one AIB channel Tx port through a
// single registered output stage.
module aib_tx_arbiter
    import aib_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int DATA_W    = AIB_TX_DATA_W,
    parameter  int MAX_BURST = AIB_ARB_MAX_BURST,
    localparam int IW        = $clog2(NUM_REQ)
) (
    input  logic                      i_aib_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        c_req_en,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]        i_req_last,
    output logic                      o_tx_valid,
    input  logic                      i_tx_ready,
    output logic [DATA_W-1:0]         o_tx_data,
    output logic [IW-1:0]             o_tx_id,
    output logic                      o_busy
);

    localparam int                CW          = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]     MAX_BURST_C = CW'(MAX_BURST);
    localparam logic [IW-1:0]     LAST_IDX    = IW'(NUM_REQ - 1);

    aib_arb_state_t    state_q, state_d;
    logic [IW-1:0]     gnt_q, gnt_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [IW-1:0]     tx_id_q, tx_id_d;

    logic [DATA_W-1:0] req_data [NUM_REQ];
    logic              pick_any;
    logic [IW-1:0]     pick_idx;
    logic              slot_free;
    logic              accept;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_data[gi] = i_req_data[gi*DATA_W +: DATA_W];
    end

    // Enable mask gates selection only; a held grant ignores it.
    aib_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_elig (i_req_valid & c_req_en),
        .i_ptr  (rr_ptr_q),
        .o_any  (pick_any),
        .o_idx  (pick_idx)
    );

    assign slot_free = !tx_valid_q || i_tx_ready;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        tx_valid_d  = tx_valid_q && !i_tx_ready;
        tx_data_d   = tx_data_q;
        tx_id_d     = tx_id_q;
        o_req_ready = '0;
        accept      = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                o_req_ready[gnt_q] = slot_free;
                accept             = i_req_valid[gnt_q] && slot_free;
                if (accept) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = req_data[gnt_q];
                    tx_id_d    = gnt_q;
                    cnt_d      = cnt_q + CW'(1);
                    // A burst-cap release leaves the rest of the burst queued
                    // at the requester; it resumes on the next grant.
                    if (i_req_last[gnt_q] || ((cnt_q + CW'(1)) == MAX_BURST_C)) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = (gnt_q == LAST_IDX) ? '0 : gnt_q + IW'(1);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_aib_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_id_q    <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_id_q    <= tx_id_d;
        end
    end

    assign o_tx_valid = tx_valid_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_id    = tx_id_q;
    assign o_busy     = (state_q == ARB_GRANT);

endmodule

// File: doc/aib_tx_arbiter.md
# aib_tx_arbiter

Round-robin arbiter that shares one AIB channel Tx datapath (72-bit valid/ready beat interface into the channel adapter) among several on-chip requesters. Each requester sends bursts delimited by a `last` flag. A grant is held until the burst completes or a maximum beat count is reached. Beats pass through a single registered output stage, so the channel input is timing-clean. The block sits between the requester fabric and the channel's `i_tx_valid`/`o_tx_ready`/`i_tx_data` port, in the `i_aib_clk` domain.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `DATA_W`, default 72: beat width; matches the channel Tx data width.
- `MAX_BURST`, default 16: maximum beats per grant before a forced re-arbitration; must be ≥1.
- `i_aib_clk`  in  1  AIB channel clock. This is the only clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `c_req_en`  in  NUM_REQ  per-requester enable mask. It is static configuration and affects selection only.
- `i_req_valid`  in  NUM_REQ  requester beat valid.
- `o_req_ready`  out  NUM_REQ  requester beat ready. At most one bit is set at a time.
- `i_req_data`  in  NUM_REQ×DATA_W  requester beat data, packed with requester r at `[r*DATA_W +: DATA_W]`.
- `i_req_last`  in  NUM_REQ  last beat of the burst.
- `o_tx_valid`  out  1  beat valid to the channel adapter.
- `i_tx_ready`  in  1  channel adapter ready.
- `o_tx_data`  out  DATA_W  beat data to the channel adapter.
- `o_tx_id`  out  $clog2(NUM_REQ)  source requester of the current `o_tx_data` beat.
- `o_busy`  out  1  set while a grant is held.

## Operation
**FSM states**
- IDLE: no grant is held.
- GRANT: a grant is held by requester `gnt`.

**Transition from IDLE**
- Eligible requesters are `i_req_valid & c_req_en`.
- If any requester is eligible, select the first eligible index searching upward from `rr_ptr`, with wrap-around.
- Register `gnt` and move to GRANT. The beat counter `cnt` is cleared.
- If no requester is eligible, stay in IDLE.

**Beat acceptance in GRANT**
- `o_req_ready[gnt] = !o_tx_valid || i_tx_ready`. All other ready bits are 0.
- A beat is accepted when `i_req_valid[gnt] && o_req_ready[gnt]`.
- On acceptance, load the output register with `i_req_data[gnt]`, `o_tx_id` = `gnt`, and `o_tx_valid` = 1. Increment `cnt`.

**Release from GRANT**
- Release happens on an accepted beat when `i_req_last[gnt]`, or when `cnt+1 == MAX_BURST`.
- On release: go to IDLE and set `rr_ptr` = (`gnt`+1) mod NUM_REQ.
- A forced release (MAX_BURST reached) does not alter the data. The requester's next burst continues when it is re-granted.

**Output register**
- `o_tx_valid` clears when `i_tx_ready` is high and no new beat is loaded in the same cycle.
- While `o_tx_valid && !i_tx_ready`, `o_tx_data` and `o_tx_id` hold stable.

**Masking and idle behaviour**
- Deasserting `c_req_en[gnt]` mid-burst does not drop the grant. The burst completes normally.
- In GRANT with `i_req_valid[gnt]` low, the grant is held and the FSM waits. There is no timeout.

**Width rules**
- `cnt` is $clog2(MAX_BURST+1) bits.
- `rr_ptr` and `gnt` are $clog2(NUM_REQ) bits. Wrap from NUM_REQ−1 to 0 is explicit, so non-power-of-two NUM_REQ is handled.

## Timing
**Reset values**
- Outputs: `o_tx_valid` 0, `o_tx_data` 0, `o_tx_id` 0, `o_req_ready` all 0, `o_busy` 0.
- Internal state: FSM IDLE, `rr_ptr` 0, `gnt` 0, `cnt` 0.
- Reset is asynchronous: outputs clear immediately when `i_rst_n` falls, and any in-flight beat is discarded.

**Arbitration**
- Arbitration takes 1 cycle. An eligible request seen in IDLE at edge N produces `o_req_ready[gnt]` and `o_busy` high after edge N.
- After each release there is exactly one IDLE bubble cycle.

**Data path**
- Latency is 1 cycle: a beat accepted at edge N is presented on `o_tx_valid`/`o_tx_data` after edge N.
- Throughput is 1 beat per cycle within a grant while `i_tx_ready` stays high.

**Simultaneous events**
- Output-register drain and load in the same cycle: the new beat replaces the old, and `o_tx_valid` stays 1.
- Last beat accepted while other requesters are waiting: the grant is released and the next winner is picked in the following IDLE cycle.

## Structure
- Shared package `aib_pkg` holds:
  - the state enum `aib_arb_state_t` {ARB_IDLE, ARB_GRANT};
  - default constants `AIB_TX_DATA_W` = 72 and `AIB_ARB_MAX_BURST` = 16.
- One sub-module, `aib_rr_pick`: combinational round-robin picker. Inputs are the eligibility vector and `rr_ptr`. Outputs are `any` and `idx`.
- All state lives in `aib_tx_arbiter`.

## Test plan
- **Single burst:** requester 0 sends 3 beats (0xA1, 0xA2, 0xA3), last on the third, `i_tx_ready`=1 → `o_tx_data` shows A1, A2, A3 on consecutive cycles starting 1 cycle after the first acceptance. `o_tx_id`=0 throughout. `o_busy` drops after the third acceptance.
- **Fairness:** all 4 requesters valid continuously with 1-beat bursts → grant order 0,1,2,3,0,1, with one idle cycle between grants.
- **Backpressure:** `i_tx_ready` held low for 5 cycles mid-burst on requester 2 → `o_tx_data` and `o_tx_id` stable; no beat lost or duplicated; 8-beat sequence received intact.
- **Forced release:** MAX_BURST=16; requester 1 streams 20 beats with no last while requester 3 waits → 16 beats from 1, then requester 3's burst, then the remaining 4 beats from 1.
- **Mask:** `c_req_en`=4'b1011 with all valid → requester 2 is never granted. Clearing `c_req_en[gnt]` mid-burst → that burst still completes.
- **Reset mid-burst:** assert `i_rst_n`=0 during the beat-3 transfer → all outputs 0 immediately. After release with all requesters valid, the first grant goes to requester 0.
